// File: rtl/xadc_drp_sequencer.sv
// rtl/xadc_drp_sequencer.sv - XADC DRP sweep-on-EOC reader with arbitrated config writes
module xadc_drp_sequencer #(
  parameter int                  NUM_CH   = 2,
  parameter logic [7*NUM_CH-1:0] CH_ADDRS = {7'h10, 7'h03},
  parameter int                  TIMEOUT  = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        eoc_in,
  output logic        den_out,
  output logic        dwe_out,
  output logic [6:0]  daddr_out,
  output logic [15:0] di_out,
  input  logic [15:0] do_in,
  input  logic        drdy_in,
  input  logic        cfg_req,
  input  logic [6:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  output logic        cfg_ack,
  output logic        sample_valid,
  output logic [2:0]  sample_ch,
  output logic [15:0] sample_value,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int         CW       = $clog2(TIMEOUT + 1);
  localparam logic [2:0] LAST_IDX = 3'(NUM_CH - 1);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT} state_t;

  state_t          state, state_nxt;
  logic            pending;
  logic [2:0]      idx;
  logic [CW-1:0]   tcnt;
  logic            wait_expired;
  logic            pending_clr;
  logic [6:0]      ch_addr;

  assign wait_expired = (tcnt == CW'(TIMEOUT - 1));
  assign pending_clr  = (state == IDLE) && pending;

  always_comb begin
    ch_addr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx == 3'(i)) ch_addr = CH_ADDRS[7*i +: 7];
    end
  end

  always_comb begin
    state_nxt = state;
    den_out   = 1'b0;
    dwe_out   = 1'b0;
    daddr_out = '0;
    di_out    = '0;
    case (state)
      IDLE: begin
        // An EOC arriving this cycle also blocks a write start, so a sweep always wins the tie.
        if (pending)                  state_nxt = RD_ISSUE;
        else if (cfg_req && !eoc_in)  state_nxt = WR_ISSUE;
      end
      RD_ISSUE: begin
        den_out   = 1'b1;
        daddr_out = ch_addr;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (drdy_in)           state_nxt = (idx < LAST_IDX) ? RD_ISSUE : IDLE;
        else if (wait_expired) state_nxt = IDLE;
      end
      WR_ISSUE: begin
        den_out   = 1'b1;
        dwe_out   = 1'b1;
        daddr_out = cfg_addr;
        di_out    = cfg_data;
        state_nxt = WR_WAIT;
      end
      WR_WAIT: begin
        if (drdy_in || wait_expired) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pending      <= 1'b0;
      idx          <= '0;
      tcnt         <= '0;
      cfg_ack      <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_value <= '0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      cfg_ack      <= 1'b0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;

      // A new EOC landing on the cycle the flag is consumed re-arms it without an overrun.
      if (eoc_in) begin
        if (pending && !pending_clr) overrun <= 1'b1;
        pending <= 1'b1;
      end else if (pending_clr) begin
        pending <= 1'b0;
      end

      case (state)
        IDLE: if (pending) idx <= '0;
        RD_ISSUE, WR_ISSUE: tcnt <= '0;
        RD_WAIT: begin
          if (drdy_in) begin
            sample_valid <= 1'b1;
            sample_ch    <= idx;
            sample_value <= do_in;
            if (idx < LAST_IDX) idx <= idx + 3'd1;
          end else if (wait_expired) begin
            timeout_err <= 1'b1;
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end
        WR_WAIT: begin
          if (drdy_in)           cfg_ack     <= 1'b1;
          else if (wait_expired) timeout_err <= 1'b1;
          else                   tcnt        <= tcnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
